// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush control, flush hold, livelock watchdog.
// Ports: clk, rst_n (async, active-low), stall_req, flush_req -> stall_state, flush_state,
// wdog_timeout, perf_stall_cyc, perf_flush_cnt. Perf counters exist only with STALL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 6,
    parameter int FLUSH_CYC  = 1,
    parameter int WDOG_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    output logic [STAGES-1:0] stall_state,
    output logic [STAGES-1:0] flush_state,
    output logic              wdog_timeout,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
);

    localparam int HW = $clog2(FLUSH_CYC + 1);
    localparam logic [HW-1:0] HLOAD = HW'(FLUSH_CYC - 1);
    localparam logic [15:0] WLIM = 16'(WDOG_LIMIT);

    logic [STAGES-1:0] stall_comb;
    logic [STAGES-1:0] fmask_new;
    logic [STAGES-1:0] hold_mask;
    logic [STAGES-1:0] held;
    logic [STAGES-1:0] flush_i;
    logic [STAGES-1:0] stall_i;
    logic [HW-1:0]     hold_cnt;
    logic [15:0]       wdog_cnt;
    logic              wdog_q;
    logic              accepted;
    logic              stalled;
    logic              found;
    logic              older;
    logic              run;
    int                kidx;

    // Stall propagates to every younger slot; the highest flushing stage
    // kills everything below it unless an older stage is frozen.
    always_comb begin
        stall_comb = '0;
        fmask_new  = '0;
        found      = 1'b0;
        older      = 1'b0;
        run        = 1'b0;
        kidx       = 0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            run           = run | stall_req[j];
            stall_comb[j] = run;
        end
        for (int i = 0; i < STAGES; i++) begin
            if (flush_req[i]) begin
                found = 1'b1;
                kidx  = i;
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            if (found && i < kidx) fmask_new[i] = 1'b1;
            if (found && i > kidx && stall_req[i]) older = 1'b1;
        end
        accepted = found && !older;
    end

    assign held    = (hold_cnt != '0) ? hold_mask : '0;
    assign flush_i = (accepted ? fmask_new : '0) | held;
    assign stall_i = stall_comb & ~flush_i;
    assign stalled = (stall_i != '0);

    assign flush_state  = rst_n ? flush_i : '0;
    assign stall_state  = rst_n ? stall_i : '1;
    assign wdog_timeout = wdog_q;

    // A new flush reloads the counter and unions with any live hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            hold_mask <= '0;
        end else if (accepted) begin
            hold_cnt  <= HLOAD;
            hold_mask <= (HLOAD != '0) ? (fmask_new | held) : '0;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) hold_mask <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else if (stalled) begin
            if (wdog_cnt != WLIM) wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_cnt == WLIM - 16'd1) wdog_q <= 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] st_cnt;
    logic [31:0] fl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            if (stalled)  st_cnt <= st_cnt + 32'd1;
            if (accepted) fl_cnt <= fl_cnt + 32'd1;
        end
    end

    assign perf_stall_cyc = st_cnt;
    assign perf_flush_cnt = fl_cnt;
`else
    assign perf_stall_cyc = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// checked against an event-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int S  = 6;
    localparam int FC = 2;
    localparam int WL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [S-1:0] stall_req = '0;
    logic [S-1:0] flush_req = '0;
    logic [S-1:0] stall_state;
    logic [S-1:0] flush_state;
    logic         wdog_timeout;
    logic [31:0]  perf_stall_cyc;
    logic [31:0]  perf_flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int t = 0;
    int last_acc = -1000;
    int chain_mask = 0;
    int run_len = 0;
    int tmo = 0;
    int m_st = 0;
    int m_fl = 0;

    pipe_hazard_ctrl #(
        .STAGES(S), .FLUSH_CYC(FC), .WDOG_LIMIT(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_req(stall_req), .flush_req(flush_req),
        .stall_state(stall_state), .flush_state(flush_state),
        .wdog_timeout(wdog_timeout),
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int top_bit(input int v);
        int h = -1;
        for (int i = 0; i < S; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        last_acc   = -1000;
        chain_mask = 0;
        run_len    = 0;
        tmo        = 0;
        m_st       = 0;
        m_fl       = 0;
    endtask

    task automatic chk_perf(input int est, input int efl);
`ifdef STALL_PERF_EN
        chk("perf_stall", perf_stall_cyc, est);
        chk("perf_flush", perf_flush_cnt, efl);
`else
        chk("perf_stall", perf_stall_cyc, 0);
        chk("perf_flush", perf_flush_cnt, 0);
`endif
    endtask

    // Called at posedge+1; reset asserted now, released one edge later.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_stall", stall_state, 32'h3f);
        chk("rst_flush", flush_state, 0);
        chk("rst_tmo", wdog_timeout, 0);
        model_reset();
        chk_perf(0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called at posedge+1; checks at negedge, advances model at posedge.
    task automatic cycle(input int s, input int f);
        int hs, k, sc, fm, held, fs, ss;
        bit acc;
        stall_req = S'(s);
        flush_req = S'(f);
        hs = top_bit(s);
        k  = top_bit(f);
        sc = (hs < 0) ? 0 : ((1 << (hs + 1)) - 1);
        fm = (k < 0) ? 0 : ((1 << k) - 1);
        acc  = (k >= 0) && ((s >> (k + 1)) == 0);
        held = ((t - last_acc) < FC) ? chain_mask : 0;
        fs = (acc ? fm : 0) | held;
        ss = sc & ~fs & ((1 << S) - 1);
        @(negedge clk);
        chk("stall_state", stall_state, ss);
        chk("flush_state", flush_state, fs);
        chk("wdog_timeout", wdog_timeout, tmo);
        chk_perf(m_st, m_fl);
        @(posedge clk);
        if (acc) begin
            chain_mask = fm | held;
            last_acc   = t;
        end
        run_len = (ss != 0) ? run_len + 1 : 0;
        if (run_len >= WL) tmo = 1;
        if (ss != 0) m_st++;
        if (acc) m_fl++;
        t++;
        #1;
    endtask

    initial begin
        #2;
        chk("init_stall", stall_state, 32'h3f);
        chk("init_flush", flush_state, 0);
        @(posedge clk);
        #1;
        do_reset();

        // stall priority
        cycle(6'b010000, 0);
        cycle(6'b000100, 0);
        cycle(6'b000000, 0);

        // flush hold
        do_reset();
        cycle(0, 6'b001000);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);

        // flush vs stall
        do_reset();
        cycle(6'b000100, 6'b001000);
        cycle(0, 0);
        cycle(0, 0);
        cycle(6'b010000, 6'b001000);
        cycle(0, 0);

        // overlapping flush
        do_reset();
        cycle(0, 6'b000100);
        cycle(0, 6'b010000);
        cycle(0, 0);
        cycle(0, 0);

        // oldest-stage flush is always accepted
        cycle(6'b100000, 6'b100000);
        cycle(0, 0);

        // watchdog trips after WL stalled cycles and sticks
        do_reset();
        repeat (WL) cycle(6'b000001, 0);
        cycle(0, 0);
        cycle(0, 0);

        // broken stall run does not trip
        do_reset();
        repeat (3) cycle(6'b000001, 0);
        cycle(0, 0);
        repeat (3) cycle(6'b000001, 0);
        cycle(0, 0);

        // async reset in the middle of a hold
        do_reset();
        cycle(0, 6'b001000);
        stall_req = '0;
        flush_req = '0;
        #2;
        chk("mid_hold", flush_state, 32'h07);
        do_reset();
        cycle(0, 0);
        cycle(0, 0);

        // random traffic with sparse requests
        for (int n = 0; n < 400; n++) begin
            int s, f;
            s = 0;
            f = 0;
            for (int b = 0; b < S; b++) begin
                if ($urandom_range(0, 9) == 0) s |= (1 << b);
                if ($urandom_range(0, 11) == 0) f |= (1 << b);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle(s, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
